// File: rtl/pipe_run_ctrl_pkg.sv
//------------------------------------------------------------------------------
// pipe_run_ctrl_pkg : state encoding shared by the sequencer and display mux
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipe_run_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_BREAK  = 3'd3,
    ST_HALTED = 3'd4,
    ST_FLUSH  = 3'd5
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_run_ctrl_btn_edge_sync.sv
//------------------------------------------------------------------------------
// btn_edge_sync : button synchroniser followed by a one-cycle rising-edge pulse
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST,
  input  logic btn_in,
  output logic btn_pe
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign btn_pe = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/pipe_run_ctrl.sv
//------------------------------------------------------------------------------
// pipe_run_ctrl : run/step/halt sequencer owning pipeline enable and soft reset
// Optional breakpoint support: define PIPE_RUN_CTRL_BREAKPOINT_EN
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pipe_run_ctrl
  import pipe_run_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STEP_CYCLES  = 1,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic             halt_in,
  input  logic [9:0]       pc_in,
  input  logic [9:0]       bp_addr,
  input  logic             bp_en,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             halted
);

  localparam int unsigned SEQ_MAX = max_u(STEP_CYCLES, FLUSH_CYCLES);
  localparam int          SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] STEP_LOAD  = SEQ_W'(STEP_CYCLES - 1);
  localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(FLUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             run_pe, step_pe, bp_hit;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
    .clk    (clk),
    .RST    (RST),
    .btn_in (run_btn),
    .btn_pe (run_pe)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
    .clk    (clk),
    .RST    (RST),
    .btn_in (step_btn),
    .btn_pe (step_pe)
  );

`ifdef PIPE_RUN_CTRL_BREAKPOINT_EN
  logic       bp_skip_q, bp_skip_d;
  logic [9:0] skip_pc_q, skip_pc_d;

  // Leaving BREAK arms a one-shot skip so the same PC does not re-trigger.
  always_comb begin
    bp_skip_d = bp_skip_q;
    skip_pc_d = skip_pc_q;
    if ((state_q == ST_BREAK) && (run_pe || step_pe)) begin
      bp_skip_d = 1'b1;
      skip_pc_d = pc_in;
    end else if (bp_skip_q && (pc_in != skip_pc_q)) begin
      bp_skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      bp_skip_q <= 1'b0;
      skip_pc_q <= '0;
    end else begin
      bp_skip_q <= bp_skip_d;
      skip_pc_q <= skip_pc_d;
    end
  end

  assign bp_hit = bp_en & (pc_in == bp_addr) & ~bp_skip_q;
`else
  logic unused_bp;
  assign unused_bp = ^{pc_in, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    cycle_cnt_d = cycle_cnt_q;
    if (cpu_en && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (run_pe) begin
          state_d = ST_RUN;
        end else if (step_pe) begin
          state_d = ST_STEP;
          seq_d   = STEP_LOAD;
        end
      end
      ST_RUN: begin
        if (halt_in)     state_d = ST_HALTED;
        else if (bp_hit) state_d = ST_BREAK;
        else if (run_pe) state_d = ST_IDLE;
      end
      ST_STEP: begin
        if (halt_in)            state_d = ST_HALTED;
        else if (seq_q == '0)   state_d = ST_IDLE;
        else                    seq_d   = seq_q - 1'b1;
      end
      ST_BREAK: begin
        if (run_pe) begin
          state_d = ST_RUN;
        end else if (step_pe) begin
          state_d = ST_STEP;
          seq_d   = STEP_LOAD;
        end
      end
      ST_HALTED: begin
        if (run_pe) begin
          state_d     = ST_FLUSH;
          seq_d       = FLUSH_LOAD;
          cycle_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (seq_q == '0) state_d = ST_IDLE;
        else             seq_d   = seq_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cpu_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign cpu_rst   = (state_q == ST_FLUSH);
  assign halted    = (state_q == ST_HALTED);
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

`default_nettype wire

// File: doc/pipe_run_ctrl.md
Name: pipe_run_ctrl

Overview:
Run/step/halt sequencer for the five-stage pipelined CPU. It owns the global pipeline advance enable and the datapath soft-reset. It turns the board's run and step buttons into clean start, pause and single-step control, and stops on the syscall halt coming out of MEM_WB. It sits between the board I/O and the PC / pipeline-register enables, and is clocked by the divided CPU clock.

Parameters:
SYNC_STAGES, 2, synchroniser depth for each button input (minimum 2)
STEP_CYCLES, 1, pipeline cycles advanced per step press (minimum 1)
FLUSH_CYCLES, 4, cycles cpu_rst is held during restart (minimum 1)
CNT_W, 32, width of the executed-cycle counter

Ports:
clk  in  1  CPU clock (divided clock domain)
RST  in  1  asynchronous, active-low reset
run_btn  in  1  raw run/pause button, level
step_btn  in  1  raw single-step button, level
halt_in  in  1  syscall halt flag from the MEM_WB stage, level
pc_in  in  10  current PC word address
bp_addr  in  10  breakpoint PC word address
bp_en  in  1  breakpoint arm
cpu_en  out  1  pipeline advance enable (PC and stage-register pause = ~cpu_en)
cpu_rst  out  1  synchronous soft reset to PC and pipeline registers
state  out  3  encoded FSM state, for the display mux
cycle_cnt  out  CNT_W  number of cycles with cpu_en=1
halted  out  1  high while in HALTED

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; cpu_en=0; cpu_rst=0; cycle_cnt=0; halted=0; all synchroniser and edge flops cleared.
- Button handling:
  - each button passes through SYNC_STAGES flops, then a one-cycle rising-edge pulse (run_pe, step_pe);
  - a button edge changes state SYNC_STAGES+1 cycles after the raw edge;
  - held buttons produce exactly one pulse.
- Outputs are Moore, decoded from the state register:
  - cpu_en=1 only in RUN and STEP;
  - cpu_rst=1 only in FLUSH;
  - halted=1 only in HALTED.
- State encoding: IDLE=0, RUN=1, STEP=2, BREAK=3, HALTED=4, FLUSH=5.
- Transitions:
  - IDLE: run_pe -> RUN; else step_pe -> STEP (step counter loaded with STEP_CYCLES-1).
  - RUN, in priority order: halt_in -> HALTED; else bp_hit -> BREAK; else run_pe -> IDLE (pause). step_pe is ignored.
  - STEP: halt_in -> HALTED; else counter==0 -> IDLE; else decrement. Exactly STEP_CYCLES cycles have cpu_en=1.
  - BREAK: run_pe -> RUN; else step_pe -> STEP. Either way bp_skip is set.
  - HALTED: run_pe -> FLUSH (restart). step_pe is ignored.
  - FLUSH: counter loaded with FLUSH_CYCLES-1 on entry; at 0 -> IDLE. cycle_cnt is cleared on FLUSH entry.
- bp_hit = bp_en & (pc_in==bp_addr) & ~bp_skip, evaluated only in RUN.
  - bp_skip clears when pc_in differs from the PC latched at BREAK exit, so resuming never re-triggers on the same PC.
- Simultaneous events:
  - run_pe and step_pe together: run wins;
  - halt_in and bp_hit together: HALTED wins.
- cycle_cnt increments by 1 on each cycle with cpu_en=1 and saturates at all-ones (no wrap).
- halt_in is ignored outside RUN and STEP.

Optional Feature:
PIPE_RUN_CTRL_BREAKPOINT_EN.
- Defined: breakpoint logic as above.
- Undefined: bp_hit is constant 0; bp_addr, bp_en and pc_in are unused; BREAK is unreachable; no bp_skip or latched-PC flops are synthesised.

Decomposition:
- Shared package: state encoding constants (IDLE..FLUSH) and the 3-bit state width, also consumed by the display-select logic.
- One natural sub-module: btn_edge_sync (SYNC_STAGES synchroniser plus rising-edge detector), instantiated twice.

Test Plan:
- Reset, then run_btn high for 10 cycles -> cpu_en rises exactly SYNC_STAGES+1=3 cycles after the press, one pulse only, state=1.
- STEP_CYCLES=3, step press from IDLE -> cpu_en high for exactly 3 cycles, cycle_cnt=3, state returns to 0.
- RUN with bp_en=1, bp_addr=0x010, PC reaches 0x010 -> state=3, cpu_en=0 that cycle; run press -> resumes without re-breaking at 0x010.
- halt_in asserted in RUN -> halted=1, state=4; step press ignored; run press -> cpu_rst high 4 cycles, cycle_cnt=0, state=0.
- Run and step pressed the same cycle from IDLE -> state=1 (run wins); halt_in and bp_hit in the same cycle -> state=4.
- RST pulled low mid-STEP and mid-FLUSH -> all outputs 0 immediately (asynchronous), state=0.
